// File: rtl/riscv_alu_arbiter_pkg.sv
// Shared constants for the execute-stage ALU arbiter slice: ALU/branch function
// encodings, on/off/zero literals and requester identifiers.
package riscv_alu_arbiter_pkg;

   localparam logic        ON   = 1'b1;
   localparam logic        OFF  = 1'b0;
   localparam logic [31:0] ZERO = '0;

   localparam logic [3:0] ALU_FUNC_ADD  = 4'd0;
   localparam logic [3:0] ALU_FUNC_SUB  = 4'd1;
   localparam logic [3:0] ALU_FUNC_SLL  = 4'd2;
   localparam logic [3:0] ALU_FUNC_SLT  = 4'd3;
   localparam logic [3:0] ALU_FUNC_SLTU = 4'd4;
   localparam logic [3:0] ALU_FUNC_XOR  = 4'd5;
   localparam logic [3:0] ALU_FUNC_SRL  = 4'd6;
   localparam logic [3:0] ALU_FUNC_SRA  = 4'd7;
   localparam logic [3:0] ALU_FUNC_OR   = 4'd8;
   localparam logic [3:0] ALU_FUNC_AND  = 4'd9;
   localparam logic [3:0] ALU_FUNC_BR   = 4'd10;
   localparam logic [3:0] ALU_FUNC_JALR = 4'd11;

   localparam logic [2:0] BR_FUNC_EQ  = 3'd0;
   localparam logic [2:0] BR_FUNC_NE  = 3'd1;
   localparam logic [2:0] BR_FUNC_LT  = 3'd4;
   localparam logic [2:0] BR_FUNC_GE  = 3'd5;
   localparam logic [2:0] BR_FUNC_LTU = 3'd6;
   localparam logic [2:0] BR_FUNC_GEU = 3'd7;

   typedef enum logic {
      REQ_EXEC   = 1'b0,
      REQ_BRANCH = 1'b1
   } req_id_e;

   function automatic logic [1:0] req_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/riscv_alu.sv
// Combinational integer ALU with branch comparator; unrecognised functions
// produce a zero result and a not-taken branch.
module riscv_alu
   import riscv_alu_arbiter_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [3:0]       alu_func_in,
   input  logic [2:0]       br_func_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic [WIDTH-1:0] result_out,
   output logic             branch_taken_out
);

   localparam int unsigned SHW = $clog2(WIDTH);

   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] sum;
   logic             eq, lt, ltu;

   assign shamt = b_in[SHW-1:0];
   assign sum   = a_in + b_in;
   assign eq    = (a_in == b_in);
   assign lt    = ($signed(a_in) < $signed(b_in));
   assign ltu   = (a_in < b_in);

   always_comb begin
      result_out       = '0;
      branch_taken_out = OFF;
      case (alu_func_in)
         ALU_FUNC_ADD:  result_out = sum;
         ALU_FUNC_SUB:  result_out = a_in - b_in;
         ALU_FUNC_SLL:  result_out = a_in << shamt;
         ALU_FUNC_SLT:  result_out = {{(WIDTH-1){1'b0}}, lt};
         ALU_FUNC_SLTU: result_out = {{(WIDTH-1){1'b0}}, ltu};
         ALU_FUNC_XOR:  result_out = a_in ^ b_in;
         ALU_FUNC_SRL:  result_out = a_in >> shamt;
         ALU_FUNC_SRA:  result_out = $signed(a_in) >>> shamt;
         ALU_FUNC_OR:   result_out = a_in | b_in;
         ALU_FUNC_AND:  result_out = a_in & b_in;
         ALU_FUNC_BR: begin
            case (br_func_in)
               BR_FUNC_EQ:  branch_taken_out = eq;
               BR_FUNC_NE:  branch_taken_out = !eq;
               BR_FUNC_LT:  branch_taken_out = lt;
               BR_FUNC_GE:  branch_taken_out = !lt;
               BR_FUNC_LTU: branch_taken_out = ltu;
               BR_FUNC_GEU: branch_taken_out = !ltu;
               default:     branch_taken_out = OFF;
            endcase
         end
         // jump target: bit 0 is always cleared
         ALU_FUNC_JALR: result_out = {sum[WIDTH-1:1], 1'b0};
         default:       result_out = '0;
      endcase
   end

endmodule

// File: rtl/riscv_rr_arbiter2.sv
// Two-way round-robin grant; the pointer remembers the last granted requester
// and advances whenever a grant is issued.
module riscv_rr_arbiter2
   import riscv_alu_arbiter_pkg::*;
(
   input  logic       clk_in,
   input  logic       rst_n_in,
   input  logic       enable_in,
   input  logic [1:0] req_in,
   output logic [1:0] grant_out
);

   req_id_e last_q;

   always_comb begin
      grant_out = '0;
      if (enable_in) begin
         case (req_in)
            2'b01:   grant_out = 2'b01;
            2'b10:   grant_out = 2'b10;
            2'b11:   grant_out = (last_q == REQ_EXEC) ? 2'b10 : 2'b01;
            default: grant_out = '0;
         endcase
      end
   end

   // a grant is only ever issued to a valid requester, so grant == accept
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         last_q <= REQ_BRANCH;
      end else if (|grant_out) begin
         last_q <= grant_out[1] ? REQ_BRANCH : REQ_EXEC;
      end
   end

endmodule

// File: rtl/riscv_alu_arbiter.sv
// Shares one riscv_alu between the execute and branch/address requesters through
// a single registered, owner-tagged response slot.
module riscv_alu_arbiter
   import riscv_alu_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned WIDTH   = 32
) (
   input  logic                     clk_in,
   input  logic                     rst_n_in,
   input  logic                     flush_in,
   input  logic [NUM_REQ-1:0]       req_valid_in,
   output logic [NUM_REQ-1:0]       req_ready_out,
   input  logic [NUM_REQ*4-1:0]     req_alu_func_in,
   input  logic [NUM_REQ*3-1:0]     req_br_func_in,
   input  logic [NUM_REQ*WIDTH-1:0] req_a_in,
   input  logic [NUM_REQ*WIDTH-1:0] req_b_in,
   output logic [NUM_REQ-1:0]       resp_valid_out,
   input  logic [NUM_REQ-1:0]       resp_ready_in,
   output logic [WIDTH-1:0]         resp_result_out,
   output logic                     resp_branch_taken_out,
   output logic                     busy_out
);

   logic               busy_q;
   logic               owner_q;
   logic               slot_free;
   logic [NUM_REQ-1:0] grant;
   logic               accept;
   logic               sel;
   logic [3:0]         alu_func;
   logic [2:0]         br_func;
   logic [WIDTH-1:0]   alu_a, alu_b, alu_result;
   logic               alu_taken;

   assign slot_free = !busy_q || resp_ready_in[owner_q];

   riscv_rr_arbiter2 u_arb (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .enable_in (!flush_in && slot_free),
      .req_in    (req_valid_in),
      .grant_out (grant)
   );

   assign req_ready_out = grant;
   assign accept        = |grant;
   assign sel           = grant[1];

   assign alu_func = sel ? req_alu_func_in[7:4] : req_alu_func_in[3:0];
   assign br_func  = sel ? req_br_func_in[5:3]  : req_br_func_in[2:0];
   assign alu_a    = sel ? req_a_in[2*WIDTH-1:WIDTH] : req_a_in[WIDTH-1:0];
   assign alu_b    = sel ? req_b_in[2*WIDTH-1:WIDTH] : req_b_in[WIDTH-1:0];

   riscv_alu #(.WIDTH(WIDTH)) u_alu (
      .alu_func_in      (alu_func),
      .br_func_in       (br_func),
      .a_in             (alu_a),
      .b_in             (alu_b),
      .result_out       (alu_result),
      .branch_taken_out (alu_taken)
   );

   // accept takes priority over drain so a same-cycle drain+accept reloads without a bubble
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         busy_q                <= OFF;
         owner_q               <= REQ_EXEC;
         resp_result_out       <= ZERO;
         resp_branch_taken_out <= OFF;
      end else if (flush_in) begin
         busy_q <= OFF;
      end else if (accept) begin
         busy_q                <= ON;
         owner_q               <= sel;
         resp_result_out       <= alu_result;
         resp_branch_taken_out <= alu_taken;
      end else if (busy_q && resp_ready_in[owner_q]) begin
         busy_q <= OFF;
      end
   end

   assign resp_valid_out = busy_q ? req_onehot(owner_q) : '0;
   assign busy_out       = busy_q;

endmodule

// File: tb/tb_riscv_alu_arbiter.sv
// Directed bench for riscv_alu_arbiter: handshake, round-robin, backpressure,
// flush and asynchronous reset, with hand-computed expected values.
module tb_riscv_alu_arbiter;
   import riscv_alu_arbiter_pkg::*;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic        flush_in;
   logic [1:0]  req_valid_in;
   logic [1:0]  req_ready_out;
   logic [7:0]  req_alu_func_in;
   logic [5:0]  req_br_func_in;
   logic [63:0] req_a_in;
   logic [63:0] req_b_in;
   logic [1:0]  resp_valid_out;
   logic [1:0]  resp_ready_in;
   logic [31:0] resp_result_out;
   logic        resp_branch_taken_out;
   logic        busy_out;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   always #5 clk_in = ~clk_in;

   riscv_alu_arbiter #(.NUM_REQ(2), .WIDTH(32)) dut (
      .clk_in                (clk_in),
      .rst_n_in              (rst_n_in),
      .flush_in              (flush_in),
      .req_valid_in          (req_valid_in),
      .req_ready_out         (req_ready_out),
      .req_alu_func_in       (req_alu_func_in),
      .req_br_func_in        (req_br_func_in),
      .req_a_in              (req_a_in),
      .req_b_in              (req_b_in),
      .resp_valid_out        (resp_valid_out),
      .resp_ready_in         (resp_ready_in),
      .resp_result_out       (resp_result_out),
      .resp_branch_taken_out (resp_branch_taken_out),
      .busy_out              (busy_out)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic set_req(input int unsigned r, input logic [3:0] f, input logic [2:0] bf,
                          input logic [31:0] a, input logic [31:0] b);
      req_alu_func_in[r*4 +: 4] = f;
      req_br_func_in[r*3 +: 3]  = bf;
      req_a_in[r*32 +: 32]      = a;
      req_b_in[r*32 +: 32]      = b;
   endtask

   logic [3:0]  tf [5];
   logic [31:0] ta [5];
   logic [31:0] tb [5];
   logic [31:0] te [5];

   logic [1:0]  exp_g;
   int unsigned cnt0, cnt1;

   initial begin
      rst_n_in        = 1'b0;
      flush_in        = 1'b0;
      req_valid_in    = '0;
      resp_ready_in   = '0;
      req_alu_func_in = '0;
      req_br_func_in  = '0;
      req_a_in        = '0;
      req_b_in        = '0;

      tf[0] = ALU_FUNC_SLTU; ta[0] = 32'hFFFF_FFFF; tb[0] = 32'd1;  te[0] = 32'd0;
      tf[1] = ALU_FUNC_SLT;  ta[1] = 32'hFFFF_FFFF; tb[1] = 32'd1;  te[1] = 32'd1;
      tf[2] = ALU_FUNC_SLL;  ta[2] = 32'd1;         tb[2] = 32'd31; te[2] = 32'h8000_0000;
      tf[3] = ALU_FUNC_SUB;  ta[3] = 32'd9;         tb[3] = 32'd9;  te[3] = 32'd0;
      tf[4] = 4'hF;          ta[4] = 32'd5;         tb[4] = 32'd5;  te[4] = 32'd0;

      #3;
      check("rst_resp_valid", resp_valid_out, 0);
      check("rst_busy", busy_out, 0);
      check("rst_result", resp_result_out, 0);
      check("rst_taken", resp_branch_taken_out, 0);
      step();
      step();
      rst_n_in = 1'b1;

      // single op and back-to-back ops on req0
      set_req(0, ALU_FUNC_ADD, BR_FUNC_EQ, 32'd5, 32'd7);
      req_valid_in  = 2'b01;
      resp_ready_in = 2'b11;
      #1;
      check("single_ready", req_ready_out, 2'b01);
      step();
      check("single_valid", resp_valid_out, 2'b01);
      check("single_result", resp_result_out, 32'd12);
      check("single_taken", resp_branch_taken_out, 0);
      check("single_busy", busy_out, 1);
      for (int i = 0; i < 5; i++) begin
         set_req(0, tf[i], BR_FUNC_EQ, ta[i], tb[i]);
         #1;
         check("b2b_ready", req_ready_out, 2'b01);
         step();
         check("b2b_valid", resp_valid_out, 2'b01);
         check("b2b_result", resp_result_out, te[i]);
         check("b2b_taken", resp_branch_taken_out, 0);
      end
      req_valid_in = 2'b00;
      step();
      check("drain_busy", busy_out, 0);

      rst_n_in = 1'b0;
      #2;
      rst_n_in = 1'b1;
      step();

      // contention right after reset: req0 first
      set_req(0, ALU_FUNC_SUB, BR_FUNC_EQ, 32'd10, 32'd3);
      set_req(1, ALU_FUNC_BR, BR_FUNC_EQ, 32'd4, 32'd4);
      req_valid_in  = 2'b11;
      resp_ready_in = 2'b11;
      #1;
      check("cont_ready0", req_ready_out, 2'b01);
      step();
      check("cont_valid0", resp_valid_out, 2'b01);
      check("cont_result0", resp_result_out, 32'd7);
      check("cont_taken0", resp_branch_taken_out, 0);
      req_valid_in = 2'b10;
      #1;
      check("cont_ready1", req_ready_out, 2'b10);
      step();
      check("cont_valid1", resp_valid_out, 2'b10);
      check("cont_taken1", resp_branch_taken_out, 1);
      check("cont_result1", resp_result_out, 32'd0);
      req_valid_in = 2'b00;
      step();
      check("cont_drain", busy_out, 0);

      // backpressure on req1 response
      set_req(1, ALU_FUNC_JALR, BR_FUNC_EQ, 32'h1001, 32'd4);
      req_valid_in  = 2'b10;
      resp_ready_in = 2'b00;
      #1;
      check("bp_ready_acc", req_ready_out, 2'b10);
      step();
      check("bp_result", resp_result_out, 32'h1004);
      check("bp_valid", resp_valid_out, 2'b10);
      check("bp_taken", resp_branch_taken_out, 0);
      set_req(0, ALU_FUNC_ADD, BR_FUNC_EQ, 32'd1, 32'd2);
      req_valid_in  = 2'b01;
      resp_ready_in = 2'b01;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("bp_ready_hold", req_ready_out, 2'b00);
         step();
         check("bp_result_hold", resp_result_out, 32'h1004);
         check("bp_valid_hold", resp_valid_out, 2'b10);
         check("bp_busy_hold", busy_out, 1);
      end
      resp_ready_in = 2'b10;
      #1;
      check("bp_ready_release", req_ready_out, 2'b01);
      step();
      check("bp_valid_swap", resp_valid_out, 2'b01);
      check("bp_result_swap", resp_result_out, 32'd3);

      // fairness: pointer last granted req0, so req1 leads
      set_req(0, ALU_FUNC_ADD, BR_FUNC_EQ, 32'd1, 32'd1);
      set_req(1, ALU_FUNC_ADD, BR_FUNC_EQ, 32'd2, 32'd2);
      req_valid_in  = 2'b11;
      resp_ready_in = 2'b11;
      exp_g = 2'b10;
      cnt0  = 0;
      cnt1  = 0;
      for (int i = 0; i < 8; i++) begin
         #1;
         check("fair_ready", req_ready_out, exp_g);
         if (req_ready_out == 2'b01) cnt0++;
         else if (req_ready_out == 2'b10) cnt1++;
         step();
         check("fair_valid", resp_valid_out, exp_g);
         check("fair_result", resp_result_out, (exp_g == 2'b01) ? 32'd2 : 32'd4);
         exp_g = ~exp_g;
      end
      check("fair_cnt0", cnt0, 4);
      check("fair_cnt1", cnt1, 4);
      req_valid_in = 2'b00;
      step();
      check("fair_drain", busy_out, 0);

      // flush while a req0 response is held
      set_req(0, ALU_FUNC_SRA, BR_FUNC_EQ, 32'h8000_0000, 32'd4);
      req_valid_in  = 2'b01;
      resp_ready_in = 2'b00;
      #1;
      check("fl_ready_acc", req_ready_out, 2'b01);
      step();
      check("fl_result", resp_result_out, 32'hF800_0000);
      check("fl_valid", resp_valid_out, 2'b01);
      flush_in = 1'b1;
      set_req(1, ALU_FUNC_BR, BR_FUNC_NE, 32'd1, 32'd2);
      req_valid_in  = 2'b11;
      resp_ready_in = 2'b01;
      #1;
      check("fl_ready_blocked", req_ready_out, 2'b00);
      step();
      check("fl_valid_clr", resp_valid_out, 2'b00);
      check("fl_busy_clr", busy_out, 0);
      flush_in      = 1'b0;
      resp_ready_in = 2'b11;
      #1;
      check("fl_ptr_kept", req_ready_out, 2'b10);
      step();
      check("fl_after_valid", resp_valid_out, 2'b10);
      check("fl_after_taken", resp_branch_taken_out, 1);

      // asynchronous reset while a response is held
      req_valid_in  = 2'b00;
      resp_ready_in = 2'b00;
      step();
      check("ar_held", busy_out, 1);
      #3;
      rst_n_in = 1'b0;
      #1;
      check("ar_valid", resp_valid_out, 2'b00);
      check("ar_busy", busy_out, 0);
      check("ar_taken", resp_branch_taken_out, 0);
      #1;
      rst_n_in = 1'b1;
      set_req(0, ALU_FUNC_ADD, BR_FUNC_EQ, 32'd20, 32'd22);
      set_req(1, ALU_FUNC_ADD, BR_FUNC_EQ, 32'd1, 32'd1);
      req_valid_in  = 2'b11;
      resp_ready_in = 2'b11;
      #1;
      check("ar_ready", req_ready_out, 2'b01);
      step();
      check("ar_result", resp_result_out, 32'd42);
      check("ar_resp_valid", resp_valid_out, 2'b01);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
